cpu: RTL and testbench

CPU -- requirements
Module: cpu

---
 rtl/cpu_pkg.sv | 30 +++
 rtl/cpu_control.sv | 51 +++++
 rtl/cpu.sv | 94 +++++++++
 tb/tb_cpu.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared widths, opcode encodings and helpers for the single-cycle accumulator CPU.
// The pieces here are used by both the decoder and the datapath.
package cpu_pkg;

  localparam int OPC_W  = 5;
  localparam int ADDR_W = 11;
  localparam int DATA_W = 16;

  localparam logic [OPC_W-1:0] OP_HLT  = 5'b00000;
  localparam logic [OPC_W-1:0] OP_STO  = 5'b00001;
  localparam logic [OPC_W-1:0] OP_LD   = 5'b00010;
  localparam logic [OPC_W-1:0] OP_LDI  = 5'b00011;
  localparam logic [OPC_W-1:0] OP_ADD  = 5'b00100;
  localparam logic [OPC_W-1:0] OP_ADDI = 5'b00101;
  localparam logic [OPC_W-1:0] OP_SUB  = 5'b00110;
  localparam logic [OPC_W-1:0] OP_SUBI = 5'b00111;

  // Source of the next accumulator value.
  typedef enum logic [1:0] {
    ACC_HOLD = 2'd0,
    ACC_MEM  = 2'd1,
    ACC_IMM  = 2'd2,
    ACC_ALU  = 2'd3
  } acc_sel_t;

  function automatic logic [DATA_W-1:0] sign_ext(input logic [ADDR_W-1:0] operand);
    return {{(DATA_W-ADDR_W){operand[ADDR_W-1]}}, operand};
  endfunction

endpackage

// File: rtl/cpu_control.sv
// Opcode decoder: memory strobes, accumulator source, ALU operation and PC enable.
// Unlisted opcodes fall through to the defaults, which is exactly NOP behaviour.
module cpu_control
  import cpu_pkg::*;
(
  input  logic [OPC_W-1:0] opcode_s,
  output logic             rd_s,
  output logic             wr_s,
  output acc_sel_t         acc_sel_s,
  output logic             alu_sub_s,
  output logic             alu_mem_s,
  output logic             pc_en_s
);

  // Decode the current opcode into datapath controls.
  always_comb begin
    rd_s      = 1'b0;
    wr_s      = 1'b0;
    acc_sel_s = ACC_HOLD;
    alu_sub_s = 1'b0;
    alu_mem_s = 1'b0;
    pc_en_s   = 1'b1;
    case (opcode_s)
      OP_HLT:  pc_en_s = 1'b0;
      OP_STO:  wr_s = 1'b1;
      OP_LD: begin
        rd_s      = 1'b1;
        acc_sel_s = ACC_MEM;
      end
      OP_LDI:  acc_sel_s = ACC_IMM;
      OP_ADD: begin
        rd_s      = 1'b1;
        acc_sel_s = ACC_ALU;
        alu_mem_s = 1'b1;
      end
      OP_ADDI: acc_sel_s = ACC_ALU;
      OP_SUB: begin
        rd_s      = 1'b1;
        acc_sel_s = ACC_ALU;
        alu_mem_s = 1'b1;
        alu_sub_s = 1'b1;
      end
      OP_SUBI: begin
        acc_sel_s = ACC_ALU;
        alu_sub_s = 1'b1;
      end
      default: pc_en_s = 1'b1;
    endcase
  end

endmodule

// File: rtl/cpu.sv
// Single-cycle accumulator CPU: PC, ACC, immediate sign-extension and add/sub unit,
// driven by the cpu_control decoder.
module cpu
  import cpu_pkg::*;
(
  input  logic              Clock,
  input  logic              Reset,
  output logic [ADDR_W-1:0] InsAddr,
  input  logic [DATA_W-1:0] Instruction,
  output logic              Rd,
  output logic              Wr,
  output logic [ADDR_W-1:0] DataAddr,
  output logic [DATA_W-1:0] In_Data,
  input  logic [DATA_W-1:0] Out_Data
);

  logic [ADDR_W-1:0] pc_r;
  logic [DATA_W-1:0] acc_r;
  logic [OPC_W-1:0]  opcode_s;
  logic [ADDR_W-1:0] operand_s;
  logic [DATA_W-1:0] imm_s;
  logic [DATA_W-1:0] alu_b_s;
  logic [DATA_W-1:0] alu_y_s;
  logic [DATA_W-1:0] acc_next_s;
  logic [ADDR_W-1:0] pc_next_s;
  acc_sel_t          acc_sel_s;
  logic              rd_s;
  logic              wr_s;
  logic              alu_sub_s;
  logic              alu_mem_s;
  logic              pc_en_s;

  assign opcode_s  = Instruction[DATA_W-1:ADDR_W];
  assign operand_s = Instruction[ADDR_W-1:0];
  assign imm_s     = sign_ext(operand_s);

  cpu_control u_control (
    .opcode_s  (opcode_s),
    .rd_s      (rd_s),
    .wr_s      (wr_s),
    .acc_sel_s (acc_sel_s),
    .alu_sub_s (alu_sub_s),
    .alu_mem_s (alu_mem_s),
    .pc_en_s   (pc_en_s)
  );

  // Add/sub unit; second operand is either memory data or the immediate.
  always_comb begin
    if (alu_mem_s) begin
      alu_b_s = Out_Data;
    end else begin
      alu_b_s = imm_s;
    end
    if (alu_sub_s) begin
      alu_y_s = acc_r - alu_b_s;
    end else begin
      alu_y_s = acc_r + alu_b_s;
    end
  end

  // Next-state selection for ACC and PC (PC wraps naturally at its width).
  always_comb begin
    case (acc_sel_s)
      ACC_HOLD: acc_next_s = acc_r;
      ACC_MEM:  acc_next_s = Out_Data;
      ACC_IMM:  acc_next_s = imm_s;
      ACC_ALU:  acc_next_s = alu_y_s;
      default:  acc_next_s = acc_r;
    endcase
    if (pc_en_s) begin
      pc_next_s = pc_r + 11'd1;
    end else begin
      pc_next_s = pc_r;
    end
  end

  // Architectural state; reset overrides whatever instruction is executing.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      pc_r  <= 11'd0;
      acc_r <= 16'd0;
    end else begin
      pc_r  <= pc_next_s;
      acc_r <= acc_next_s;
    end
  end

  assign InsAddr  = pc_r;
  assign In_Data  = acc_r;
  assign DataAddr = operand_s;
  assign Rd       = rd_s;
  assign Wr       = wr_s;

endmodule

// File: tb/tb_cpu.sv
// Testbench for cpu: a directed vector table, directed programs with a write log,
// and random programs checked against an instruction-level reference model.
module tb_cpu;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic [10:0] ins_addr_s;
  logic [15:0] instruction_s;
  logic        rd_s;
  logic        wr_s;
  logic [10:0] data_addr_s;
  logic [15:0] in_data_s;
  logic [15:0] out_data_s;

  logic [15:0] prog [0:2047];
  logic [15:0] dmem [0:2047];
  logic        mem_clear = 1'b1;
  logic        pre_we = 1'b0;
  logic [10:0] pre_addr = 11'd0;
  logic [15:0] pre_data = 16'd0;

  int checks = 0;
  int failures = 0;
  int m_pc;
  int m_acc;
  int m_mem [2048];
  int wlog [$];

  typedef struct {
    logic [15:0] ins;
    logic        rd;
    logic        wr;
    logic [15:0] acc;
  } vec_t;
  vec_t vecs [14];
  int exp_mem0 [7];

  cpu dut (
    .Clock       (Clock),
    .Reset       (Reset),
    .InsAddr     (ins_addr_s),
    .Instruction (instruction_s),
    .Rd          (rd_s),
    .Wr          (wr_s),
    .DataAddr    (data_addr_s),
    .In_Data     (in_data_s),
    .Out_Data    (out_data_s)
  );

  always #5 Clock = ~Clock;

  assign instruction_s = prog[ins_addr_s];
  assign out_data_s    = dmem[data_addr_s];

  // Data memory environment: bulk clear, preload, or CPU store.
  always @(posedge Clock) begin
    if (mem_clear) begin
      for (int i = 0; i < 2048; i++) dmem[i] <= 16'h0000;
    end else if (pre_we) begin
      dmem[pre_addr] <= pre_data;
    end else if (wr_s) begin
      dmem[data_addr_s] <= in_data_s;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic clear_prog();
    for (int i = 0; i < 2048; i++) prog[i] = 16'h0000;
  endtask

  // Reference model: one architectural instruction step.
  task automatic model_step(input int op, input int opnd, input bit rst);
    int imm;
    imm = (opnd >= 1024) ? opnd - 2048 : opnd;
    if (op == 1) m_mem[opnd] = m_acc;
    if (rst) begin
      m_pc  = 0;
      m_acc = 0;
    end else begin
      case (op)
        2: m_acc = m_mem[opnd];
        3: m_acc = imm & 32'hFFFF;
        4: m_acc = (m_acc + m_mem[opnd]) & 32'hFFFF;
        5: m_acc = (m_acc + imm) & 32'hFFFF;
        6: m_acc = (m_acc - m_mem[opnd]) & 32'hFFFF;
        7: m_acc = (m_acc - imm) & 32'hFFFF;
        default: begin end
      endcase
      if (op != 0) m_pc = (m_pc + 1) % 2048;
    end
  endtask

  // Enter at a falling edge; leaves with PC=0, ACC=0 and Reset released.
  task automatic do_reset(input bit pre, input logic [10:0] a, input logic [15:0] d);
    Reset = 1'b1;
    mem_clear = 1'b1;
    pre_we = 1'b0;
    @(posedge Clock);
    #1;
    mem_clear = 1'b0;
    pre_we = pre;
    pre_addr = a;
    pre_data = d;
    @(posedge Clock);
    #1;
    pre_we = 1'b0;
    @(negedge Clock);
    Reset = 1'b0;
    #1;
    chk("reset_insaddr", int'(ins_addr_s), 0);
    chk("reset_acc", int'(in_data_s), 0);
    m_pc = 0;
    m_acc = 0;
    for (int i = 0; i < 2048; i++) m_mem[i] = 0;
    if (pre) m_mem[int'(a)] = int'(d);
    wlog.delete();
  endtask

  // One clock cycle checked against the model; enter and leave at a falling edge.
  task automatic cycle(input bit rst);
    logic [15:0] ins;
    int op;
    int opnd;
    Reset = rst;
    #1;
    ins  = prog[m_pc[10:0]];
    op   = int'(ins[15:11]);
    opnd = int'(ins[10:0]);
    chk("insaddr", int'(ins_addr_s), m_pc);
    chk("acc", int'(in_data_s), m_acc);
    chk("dataaddr", int'(data_addr_s), opnd);
    chk("rd", int'(rd_s), int'(op == 2 || op == 4 || op == 6));
    chk("wr", int'(wr_s), int'(op == 1));
    if (wr_s && data_addr_s == 11'd0 && !rst) wlog.push_back(int'(in_data_s));
    @(posedge Clock);
    model_step(op, opnd, rst);
    @(negedge Clock);
  endtask

  task automatic load_count_prog();
    clear_prog();
    prog[0]  = 16'h1800; prog[1]  = 16'h0800;
    prog[2]  = 16'h2801; prog[3]  = 16'h0800;
    prog[4]  = 16'h2802; prog[5]  = 16'h0800;
    prog[6]  = 16'h2803; prog[7]  = 16'h0800;
    prog[8]  = 16'h3803; prog[9]  = 16'h0800;
    prog[10] = 16'h3802; prog[11] = 16'h0800;
    prog[12] = 16'h3801; prog[13] = 16'h0800;
  endtask

  task automatic check_wlog(input string tag);
    chk({tag, "_count"}, wlog.size(), 7);
    for (int i = 0; i < 7 && i < wlog.size(); i++) chk({tag, "_value"}, wlog[i], exp_mem0[i]);
  endtask

  initial begin
    vecs[0]  = '{16'h1FFF, 1'b0, 1'b0, 16'hFFFF};
    vecs[1]  = '{16'h2801, 1'b0, 1'b0, 16'h0000};
    vecs[2]  = '{16'h1C00, 1'b0, 1'b0, 16'hFC00};
    vecs[3]  = '{16'h0807, 1'b0, 1'b1, 16'hFC00};
    vecs[4]  = '{16'h1005, 1'b1, 1'b0, 16'h1234};
    vecs[5]  = '{16'h2005, 1'b1, 1'b0, 16'h2468};
    vecs[6]  = '{16'h3005, 1'b1, 1'b0, 16'h1234};
    vecs[7]  = '{16'h3FFF, 1'b0, 1'b0, 16'h1235};
    vecs[8]  = '{16'h4123, 1'b0, 1'b0, 16'h1235};
    vecs[9]  = '{16'hFFFF, 1'b0, 1'b0, 16'h1235};
    vecs[10] = '{16'h1007, 1'b1, 1'b0, 16'hFC00};
    vecs[11] = '{16'h2C00, 1'b0, 1'b0, 16'hF800};
    vecs[12] = '{16'h3007, 1'b1, 1'b0, 16'hFC00};
    vecs[13] = '{16'h0000, 1'b0, 1'b0, 16'hFC00};
    exp_mem0 = '{0, 1, 3, 6, 3, 1, 0};

    // Directed vector table.
    clear_prog();
    for (int i = 0; i < 14; i++) prog[i] = vecs[i].ins;
    @(negedge Clock);
    do_reset(1'b1, 11'd5, 16'h1234);
    for (int i = 0; i < 14; i++) begin
      chk("tv_insaddr", int'(ins_addr_s), i);
      chk("tv_rd", int'(rd_s), int'(vecs[i].rd));
      chk("tv_wr", int'(wr_s), int'(vecs[i].wr));
      chk("tv_dataaddr", int'(data_addr_s), int'(vecs[i].ins[10:0]));
      @(posedge Clock);
      @(negedge Clock);
      #1;
      chk("tv_acc", int'(in_data_s), int'(vecs[i].acc));
    end
    chk("tv_halt_insaddr", int'(ins_addr_s), 13);

    // Accumulate/decrement program with Mem[0] write log.
    @(negedge Clock);
    load_count_prog();
    do_reset(1'b0, 11'd0, 16'h0000);
    for (int c = 0; c < 16; c++) cycle(1'b0);
    check_wlog("count_prog");
    #1;
    chk("count_final_acc", int'(in_data_s), 0);

    // Mid-program reset after five instructions, then a full rerun.
    @(negedge Clock);
    do_reset(1'b0, 11'd0, 16'h0000);
    for (int c = 0; c < 5; c++) cycle(1'b0);
    cycle(1'b1);
    #1;
    chk("midreset_insaddr", int'(ins_addr_s), 0);
    chk("midreset_acc", int'(in_data_s), 0);
    wlog.delete();
    for (int c = 0; c < 16; c++) cycle(1'b0);
    check_wlog("rerun_prog");

    // Halt at address 3 holds PC and ACC.
    clear_prog();
    prog[0] = 16'h1855;
    prog[1] = 16'h2801;
    prog[2] = 16'h0809;
    prog[3] = 16'h0000;
    @(negedge Clock);
    do_reset(1'b0, 11'd0, 16'h0000);
    for (int c = 0; c < 15; c++) begin
      cycle(1'b0);
      if (c >= 3) begin
        #1;
        chk("halt_insaddr", int'(ins_addr_s), 3);
        chk("halt_acc", int'(in_data_s), 16'h0056);
        chk("halt_rd", int'(rd_s), 0);
        chk("halt_wr", int'(wr_s), 0);
      end
    end

    // Random programs over the full address space (covers PC wrap) with one reset.
    for (int i = 0; i < 2048; i++) begin
      int k;
      int op;
      int opnd;
      k = int'($urandom_range(1, 9));
      op = (k <= 7) ? k : int'($urandom_range(8, 31));
      opnd = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 2047)) : int'($urandom_range(0, 15));
      prog[i] = {op[4:0], opnd[10:0]};
    end
    @(negedge Clock);
    do_reset(1'b0, 11'd0, 16'h0000);
    for (int c = 0; c < 2600; c++) begin
      cycle(c == 2300);
      if (c == 2048) begin
        #1;
        chk("pc_wrap", int'(ins_addr_s), 1);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
